// File: rtl/mctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mctrl_pkg
// Description : Shared link command bytes, FSM state encoding and width helpers
//               for the multi-channel UART memory controller.
// Revision    : 1.0 - initial release
// ============================================================================
package mctrl_pkg;

    localparam logic [7:0] CMD_RD = 8'hC0;
    localparam logic [7:0] CMD_WR = 8'h80;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_ADDR  = 3'd2,
        ST_AMSB  = 3'd3,
        ST_LEN   = 3'd4,
        ST_WDATA = 3'd5,
        ST_WMSB  = 3'd6,
        ST_RDATA = 3'd7
    } mctrl_state_t;

    // Whole bytes in a field of the given bit width (AB, DB).
    function automatic int nbytes(input int width);
        return width / 8;
    endfunction

    // Index width for n channels, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mctrl_rr_arb.sv
`default_nettype none
// ============================================================================
// Module      : mctrl_rr_arb
// Description : NCH-wide round-robin arbiter; search starts at the pointer,
//               which moves past the winner whenever a grant is taken.
// Revision    : 1.0 - initial release
// ============================================================================
module mctrl_rr_arb
    import mctrl_pkg::*;
#(
    parameter int NCH = 2,
    parameter int PW  = idx_w(NCH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] req,
    input  logic           advance,
    output logic [NCH-1:0] grant,
    output logic [PW-1:0]  gnt_idx,
    output logic           any_req
);

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_idx;
    logic          w_found;

    assign any_req = |req;

    always_comb begin
        grant   = '0;
        gnt_idx = '0;
        w_idx   = '0;
        w_found = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            w_idx = PW'((int'(r_ptr) + k) % NCH);
            if (!w_found && req[w_idx]) begin
                grant[w_idx] = 1'b1;
                gnt_idx      = w_idx;
                w_found      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (advance && any_req) begin
            r_ptr <= PW'((int'(gnt_idx) + 1) % NCH);
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_ctrl_uart_mc.sv
`default_nettype none
// ============================================================================
// Module      : mem_ctrl_uart_mc
// Description : Round-robin multi-channel cache request bridge onto an 8-bit
//               UART byte link. Optional RX idle timeout: MCTRL_RX_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_ctrl_uart_mc
    import mctrl_pkg::*;
#(
    parameter int NCH         = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int LEN_W       = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NCH-1:0]        c_req,
    input  logic [NCH-1:0]        c_rw,
    input  logic [NCH*LEN_W-1:0]  c_len,
    input  logic [NCH*ADDR_W-1:0] c_addr,
    input  logic [NCH*DATA_W-1:0] c_din,
    output logic [DATA_W-1:0]     c_dout,
    output logic [NCH-1:0]        c_ack,
    output logic                  c_err,
    output logic [7:0]            u_dout,
    output logic                  u_we,
    input  logic                  u_wa,
    input  logic [7:0]            u_din,
    output logic                  u_re,
    input  logic                  u_ra
);

    localparam int AB = nbytes(ADDR_W);
    localparam int DB = nbytes(DATA_W);
    localparam int PW = idx_w(NCH);

    if (NCH < 1 || NCH > 4) begin : g_chk_nch
        $error("NCH must be 1..4");
    end
    if (AB < 2 || AB > 7 || DB < 2 || DB > 7) begin : g_chk_width
        $error("ADDR_W and DATA_W must be 16..56");
    end
    if ((1 << LEN_W) < DB) begin : g_chk_len
        $error("LEN_W too narrow for DATA_W");
    end
    if (TIMEOUT_CYC < 1) begin : g_chk_timeout
        $error("TIMEOUT_CYC must be positive");
    end

    mctrl_state_t        r_state;
    logic [2:0]          r_cnt;
    logic                r_rw;
    logic [LEN_W-1:0]    r_len;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_din;
    logic [PW-1:0]       r_win;
    logic [DATA_W-1:0]   r_dout;
    logic [DATA_W-1:0]   r_rdbuf;
    logic [NCH-1:0]      r_ack;

    logic [NCH-1:0]      w_gnt;
    logic [PW-1:0]       w_gidx;
    logic                w_any;
    logic                w_adv;
    logic                w_rw_sel;
    logic [LEN_W-1:0]    w_len_sel;
    logic [LEN_W-1:0]    w_len_clamp;
    logic [ADDR_W-1:0]   w_addr_sel;
    logic [DATA_W-1:0]   w_din_sel;
    logic [6:0]          w_a7;
    logic [6:0]          w_d7;
    logic [7:0]          w_amsb;
    logic [7:0]          w_wmsb;
    logic [DATA_W-1:0]   w_rx_word;
    logic [NCH-1:0]      w_win_1h;
    logic                w_cnt_ab;
    logic                w_cnt_len;
    logic                w_tx_state;

    // No grant in the ack cycle, so a requester has one cycle to drop c_req.
    assign w_adv = (r_state == ST_IDLE) && (r_ack == '0) && w_any;

    mctrl_rr_arb #(
        .NCH (NCH),
        .PW  (PW)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (c_req),
        .advance (w_adv),
        .grant   (w_gnt),
        .gnt_idx (w_gidx),
        .any_req (w_any)
    );

    always_comb begin
        w_rw_sel   = 1'b0;
        w_len_sel  = '0;
        w_addr_sel = '0;
        w_din_sel  = '0;
        for (int k = 0; k < NCH; k++) begin
            if (w_gnt[k]) begin
                w_rw_sel   = c_rw[k];
                w_len_sel  = c_len[k*LEN_W +: LEN_W];
                w_addr_sel = c_addr[k*ADDR_W +: ADDR_W];
                w_din_sel  = c_din[k*DATA_W +: DATA_W];
            end
        end
    end

    assign w_len_clamp = (int'(w_len_sel) > DB - 1) ? LEN_W'(DB - 1) : w_len_sel;

    // Link bytes carry 7 payload bits; the MSBs travel later in a packed byte.
    assign w_a7      = 7'(r_addr >> {r_cnt, 3'b000});
    assign w_d7      = 7'(r_din >> {r_cnt, 3'b000});
    assign w_rx_word = r_rdbuf | (DATA_W'(u_din) << {r_cnt, 3'b000});
    assign w_win_1h  = NCH'(1) << r_win;
    assign w_cnt_ab  = (int'(r_cnt) == AB - 1);
    assign w_cnt_len = (int'(r_cnt) == int'(r_len));

    always_comb begin
        w_amsb = '0;
        w_wmsb = '0;
        for (int i = 0; i < AB; i++) begin
            w_amsb[i] = r_addr[8*i+7];
        end
        for (int i = 0; i < DB; i++) begin
            if (i <= int'(r_len)) begin
                w_wmsb[i] = r_din[8*i+7];
            end
        end
    end

    assign w_tx_state = (r_state != ST_IDLE) && (r_state != ST_RDATA);
    assign u_we       = w_tx_state & u_wa;
    assign u_re       = (r_state == ST_RDATA) & u_ra;
    assign c_ack      = r_ack;
    assign c_dout     = r_dout;

    always_comb begin
        u_dout = 8'h00;
        case (r_state)
            ST_CMD:   u_dout = r_rw ? CMD_RD : CMD_WR;
            ST_ADDR:  u_dout = {1'b0, w_a7};
            ST_AMSB:  u_dout = w_amsb;
            ST_LEN:   u_dout = 8'(r_len);
            ST_WDATA: u_dout = {1'b0, w_d7};
            ST_WMSB:  u_dout = w_wmsb;
            default:  u_dout = 8'h00;
        endcase
    end

`ifdef MCTRL_RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] r_to;
    logic          r_err;
    logic          w_to_hit;

    assign w_to_hit = (int'(r_to) == TIMEOUT_CYC - 1);
    assign c_err    = r_err;

    always_ff @(posedge clk) begin
        if (rst || (r_state != ST_RDATA) || u_ra) begin
            r_to <= '0;
        end else begin
            r_to <= r_to + 1'b1;
        end
    end
`else
    assign c_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_rw    <= 1'b0;
            r_len   <= '0;
            r_addr  <= '0;
            r_din   <= '0;
            r_win   <= '0;
            r_dout  <= '0;
            r_rdbuf <= '0;
            r_ack   <= '0;
`ifdef MCTRL_RX_TIMEOUT_EN
            r_err   <= 1'b0;
`endif
        end else begin
            r_ack <= '0;
`ifdef MCTRL_RX_TIMEOUT_EN
            r_err <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (w_adv) begin
                        r_rw    <= w_rw_sel;
                        r_len   <= w_len_clamp;
                        r_addr  <= w_addr_sel;
                        r_din   <= w_din_sel;
                        r_win   <= w_gidx;
                        r_state <= ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (u_wa) begin
                        r_cnt   <= '0;
                        r_state <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (u_wa) begin
                        if (w_cnt_ab) r_state <= ST_AMSB;
                        else          r_cnt   <= r_cnt + 3'd1;
                    end
                end
                ST_AMSB: begin
                    if (u_wa) r_state <= ST_LEN;
                end
                ST_LEN: begin
                    if (u_wa) begin
                        r_cnt   <= '0;
                        r_rdbuf <= '0;
                        r_state <= r_rw ? ST_RDATA : ST_WDATA;
                    end
                end
                ST_WDATA: begin
                    if (u_wa) begin
                        if (w_cnt_len) r_state <= ST_WMSB;
                        else           r_cnt   <= r_cnt + 3'd1;
                    end
                end
                ST_WMSB: begin
                    if (u_wa) begin
                        r_ack   <= w_win_1h;
                        r_state <= ST_IDLE;
                    end
                end
                ST_RDATA: begin
                    if (u_ra) begin
                        r_rdbuf <= w_rx_word;
                        if (w_cnt_len) begin
                            r_dout  <= w_rx_word;
                            r_ack   <= w_win_1h;
                            r_state <= ST_IDLE;
                        end else begin
                            r_cnt <= r_cnt + 3'd1;
                        end
                    end
`ifdef MCTRL_RX_TIMEOUT_EN
                    else if (w_to_hit) begin
                        r_dout  <= '0;
                        r_ack   <= w_win_1h;
                        r_err   <= 1'b1;
                        r_state <= ST_IDLE;
                    end
`endif
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl_uart_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_ctrl_uart_mc
// Description : Scoreboard bench for mem_ctrl_uart_mc: expected link bytes and
//               acks are queued at issue time and popped by independent monitors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_ctrl_uart_mc;

    localparam int NCH    = 2;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 2;
    localparam int DB     = DATA_W / 8;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NCH-1:0]        c_req;
    logic [NCH-1:0]        c_rw;
    logic [NCH*LEN_W-1:0]  c_len;
    logic [NCH*ADDR_W-1:0] c_addr;
    logic [NCH*DATA_W-1:0] c_din;
    logic [DATA_W-1:0]     c_dout;
    logic [NCH-1:0]        c_ack;
    logic                  c_err;
    logic [7:0]            u_dout;
    logic                  u_we;
    logic                  u_wa;
    logic [7:0]            u_din;
    logic                  u_re;
    logic                  u_ra;

    mem_ctrl_uart_mc #(
        .NCH         (NCH),
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .LEN_W       (LEN_W),
        .TIMEOUT_CYC (1024)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .c_req  (c_req),
        .c_rw   (c_rw),
        .c_len  (c_len),
        .c_addr (c_addr),
        .c_din  (c_din),
        .c_dout (c_dout),
        .c_ack  (c_ack),
        .c_err  (c_err),
        .u_dout (u_dout),
        .u_we   (u_we),
        .u_wa   (u_wa),
        .u_din  (u_din),
        .u_re   (u_re),
        .u_ra   (u_ra)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          ch;
        bit          rd;
        logic [31:0] dout;
    } ack_t;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] txq[$];
    logic [7:0] rxq[$];
    ack_t       ackq[$];
    int         wa_mode = 0;
    int         ra_mode = 0;
    int         rptr = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference: link image of one transaction from the protocol rules.
    task automatic expect_txn(input int ch, input bit rw, input int len,
                              input logic [31:0] addr, input logic [31:0] din,
                              input logic [31:0] rxw);
        int          l;
        logic [7:0]  m;
        logic [31:0] d;
        ack_t        a;
        l = (len > DB - 1) ? DB - 1 : len;
        txq.push_back(rw ? 8'hC0 : 8'h80);
        m = 0;
        for (int i = 0; i < 4; i++) begin
            txq.push_back(8'((addr >> (8 * i)) & 32'h7F));
            m = m | 8'(((addr >> (8 * i + 7)) & 1) << i);
        end
        txq.push_back(m);
        txq.push_back(8'(l));
        d = 0;
        if (!rw) begin
            m = 0;
            for (int i = 0; i <= l; i++) begin
                txq.push_back(8'((din >> (8 * i)) & 32'h7F));
                m = m | 8'(((din >> (8 * i + 7)) & 1) << i);
            end
            txq.push_back(m);
        end else begin
            for (int i = 0; i <= l; i++) begin
                rxq.push_back(8'(rxw >> (8 * i)));
                d = d + (((rxw >> (8 * i)) & 32'hFF) << (8 * i));
            end
        end
        a.ch = ch; a.rd = rw; a.dout = d;
        ackq.push_back(a);
        rptr = (ch + 1) % NCH;
    endtask

    task automatic drive_req(input int ch, input bit rw, input int len,
                             input logic [31:0] addr, input logic [31:0] din);
        c_req[ch]                  = 1'b1;
        c_rw[ch]                   = rw;
        c_len[ch*LEN_W +: LEN_W]   = LEN_W'(len);
        c_addr[ch*ADDR_W +: ADDR_W] = addr;
        c_din[ch*DATA_W +: DATA_W] = din;
    endtask

    // Cycle 0 is the grant cycle; lat is the cycle of the first ack seen.
    task automatic wait_acks(input logic [NCH-1:0] pend_in, output int lat);
        logic [NCH-1:0] pend;
        int cyc;
        pend = pend_in; cyc = 0; lat = -1;
        while (pend != 0 && cyc < 3000) begin
            @(negedge clk);
            for (int k = 0; k < NCH; k++) begin
                if (c_ack[k] && pend[k]) begin
                    c_req[k] = 1'b0;
                    pend[k]  = 1'b0;
                    if (lat < 0) lat = cyc;
                end
            end
            cyc++;
        end
        if (pend != 0) begin
            checks++; errors++;
            $display("FAIL ack_timeout pending %b after %0d cycles", pend, cyc);
            c_req = '0;
        end
        @(posedge clk); #1;
    endtask

    task automatic run_one(input int ch, input bit rw, input int len,
                           input logic [31:0] addr, input logic [31:0] din,
                           input logic [31:0] rxw, output int lat);
        expect_txn(ch, rw, len, addr, din, rxw);
        drive_req(ch, rw, len, addr, din);
        wait_acks(NCH'(1) << ch, lat);
    endtask

    task automatic run_pair(input bit rw0, input bit rw1);
        int f, lat;
        logic [31:0] a0, a1, d0, d1, r0, r1;
        int l0, l1;
        a0 = $urandom; a1 = $urandom; d0 = $urandom; d1 = $urandom;
        r0 = $urandom; r1 = $urandom;
        l0 = $urandom_range(0, 3); l1 = $urandom_range(0, 3);
        f = rptr;
        if (f == 0) begin
            expect_txn(0, rw0, l0, a0, d0, r0);
            expect_txn(1, rw1, l1, a1, d1, r1);
        end else begin
            expect_txn(1, rw1, l1, a1, d1, r1);
            expect_txn(0, rw0, l0, a0, d0, r0);
        end
        drive_req(0, rw0, l0, a0, d0);
        drive_req(1, rw1, l1, a1, d1);
        wait_acks(2'b11, lat);
    endtask

    // TX scoreboard.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (!rst && u_we) begin
                checks++;
                if (txq.size() == 0) begin
                    errors++;
                    $display("FAIL tx_unexpected got %02h expected none", u_dout);
                end else begin
                    e = txq.pop_front();
                    if (u_dout !== e) begin
                        errors++;
                        $display("FAIL tx_byte got %02h expected %02h", u_dout, e);
                    end
                end
            end
        end
    end

    // Ack scoreboard.
    initial begin
        ack_t a;
        forever begin
            @(negedge clk);
            if (!rst && c_ack !== '0) begin
                checks++;
                if (ackq.size() == 0) begin
                    errors++;
                    $display("FAIL ack_unexpected got c_ack=%b expected none", c_ack);
                end else begin
                    a = ackq.pop_front();
                    if (c_ack !== (NCH'(1) << a.ch) || c_err !== 1'b0 ||
                        (a.rd && c_dout !== a.dout)) begin
                        errors++;
                        $display("FAIL ack got ack=%b err=%b dout=%h expected ack=%b err=0 dout=%h",
                                 c_ack, c_err, c_dout, NCH'(1) << a.ch, a.dout);
                    end
                end
            end
        end
    end

    // Link-side FIFO models.
    initial begin
        bit cons, tgl;
        u_wa = 1'b0; u_ra = 1'b0; u_din = 8'h00; tgl = 1'b0;
        forever begin
            @(negedge clk);
            cons = u_re;
            @(posedge clk); #1;
            if (cons && rxq.size() > 0) void'(rxq.pop_front());
            tgl  = ~tgl;
            u_wa = (wa_mode == 0) ? 1'b1 : (wa_mode == 1) ? tgl : 1'($urandom_range(0, 1));
            u_ra = (rxq.size() > 0) && (ra_mode == 0 || $urandom_range(0, 1) == 1);
            u_din = (rxq.size() > 0) ? rxq[0] : 8'h00;
        end
    end

    initial begin
        int lat;
        rst = 1'b1; c_req = '0; c_rw = '0; c_len = '0; c_addr = '0; c_din = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_c_ack", 64'(c_ack), 0);
        chk("rst_c_err", 64'(c_err), 0);
        chk("rst_c_dout", 64'(c_dout), 0);
        chk("rst_u_we", 64'(u_we), 0);
        chk("rst_u_re", 64'(u_re), 0);
        chk("rst_u_dout", 64'(u_dout), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_one(0, 1'b0, 3, 32'h12345678, 32'hDEADBEEF, 0, lat);
        chk("wr_latency", 64'(lat), 13);
        run_one(1, 1'b1, 1, 32'h80000004, 0, 32'h00001234, lat);
        chk("rd_latency", 64'(lat), 10);

        run_pair(1'b1, 1'b1);
        run_pair(1'b1, 1'b1);

        wa_mode = 1;
        run_one(0, 1'b0, 3, 32'h12345678, 32'hDEADBEEF, 0, lat);
        checks++;
        if (lat < 24 || lat > 25) begin
            errors++;
            $display("FAIL wr_toggle_latency got %0d expected 24..25", lat);
        end
        wa_mode = 0;

        // Reset while the address bytes are going out.
        expect_txn(0, 1'b0, 3, 32'hA5A5F00D, 32'h01020304, 0);
        drive_req(0, 1'b0, 3, 32'hA5A5F00D, 32'h01020304);
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1; c_req = '0;
        @(posedge clk); #1;
        txq.delete();
        void'(ackq.pop_back());
        rptr = 0;
        @(negedge clk);
        chk("mid_rst_c_ack", 64'(c_ack), 0);
        chk("mid_rst_c_dout", 64'(c_dout), 0);
        chk("mid_rst_u_we", 64'(u_we), 0);
        chk("mid_rst_u_re", 64'(u_re), 0);
        chk("mid_rst_u_dout", 64'(u_dout), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        run_one(1, 1'b0, 2, 32'h00FF80FF, 32'h00C0FFEE, 0, lat);
        chk("post_rst_latency", 64'(lat), 12);

        for (int n = 0; n < 40; n++) begin
            wa_mode = $urandom_range(0, 2);
            ra_mode = $urandom_range(0, 1);
            if ($urandom_range(0, 3) == 0) begin
                run_pair(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end else begin
                run_one($urandom_range(0, NCH - 1), 1'($urandom_range(0, 1)),
                        $urandom_range(0, 3), $urandom, $urandom, $urandom, lat);
            end
        end

        wa_mode = 0; ra_mode = 0;
        repeat (30) @(negedge clk);
        chk("queues_drained", 64'(txq.size() + ackq.size() + rxq.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_ctrl_uart_mc.md
Name: mem_ctrl_uart_mc

Overview:
- Multi-channel, parametrised successor to the single-port UART memory controller (north bridge).
- Arbitrates NCH cache-side request channels round-robin.
- Serialises each request onto the 8-bit UART byte link (command, address, length, write data) and deserialises read data back.
- Sits between the L1 caches (I$/D$) and the UART byte FIFOs.

Parameters:
- NCH, 2, number of cache request channels (1..4)
- ADDR_W, 32, address width; multiple of 8, 16..56 (address bytes AB=ADDR_W/8 <= 7)
- DATA_W, 32, data width; multiple of 8, 16..56 (data bytes DB=DATA_W/8 <= 7)
- LEN_W, 2, width of length field; len = bytes-1, must satisfy 2^LEN_W >= DB
- TIMEOUT_CYC, 1024, RX idle timeout in cycles (used only with optional feature)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- c_req  in  NCH  per-channel request valid; held until c_ack
- c_rw  in  NCH  1=read, 0=write, per channel
- c_len  in  NCH*LEN_W  per-channel length (bytes-1)
- c_addr  in  NCH*ADDR_W  per-channel byte address
- c_din  in  NCH*DATA_W  per-channel write data, little-endian
- c_dout  out  DATA_W  read data; valid in the c_ack cycle
- c_ack  out  NCH  one-cycle completion pulse for the served channel
- c_err  out  1  error flag qualifying c_ack (timeout only)
- u_dout  out  8  TX byte
- u_we  out  1  TX byte write strobe
- u_wa  in  1  TX FIFO can accept a byte
- u_din  in  8  RX byte
- u_re  out  1  RX byte pop strobe
- u_ra  in  1  RX byte available

Behaviour:
- Single clock; reset synchronous, active-high, on clk. Reset values: state IDLE, c_ack=0, c_err=0, c_dout=0, u_we=0, u_re=0, u_dout=0, round-robin pointer=0.
- Reset mid-transaction abandons it: no ack; bytes already sent are not retracted.
- TX handshake: u_we = tx-state & u_wa; byte consumed in that cycle; FSM advances same edge. u_dout is driven whenever in a tx-state.
- RX handshake: u_re = RDATA & u_ra; u_din captured at that edge.
- FSM states: IDLE -> CMD -> ADDR -> AMSB -> LEN -> {WDATA -> WMSB | RDATA} -> IDLE. A byte counter indexes ADDR/WDATA/RDATA.
- IDLE:
  - if any c_req, grant round-robin starting at pointer; latch rw/len/addr/din of the winner.
  - pointer = winner+1 mod NCH.
  - go CMD.
  - Request fields may change after the grant cycle.
- CMD: send 0xC0 (read) or 0x80 (write).
- ADDR: AB bytes, byte i sends {1'b0, addr[8i+6:8i]}, i=0 first.
- AMSB: one byte {zero-pad, addr[8i+7] for i=AB-1..0}, bit i = MSB of address byte i.
- LEN: send {zero-pad, len}.
- WDATA: len+1 bytes, same 7-bit split as ADDR. WMSB: packed MSBs of the sent bytes only; unsent bits are 0.
- RDATA: receive len+1 raw 8-bit bytes, little-endian into c_dout; bytes above len are zero.
- Completion: c_ack[winner] pulses the cycle after the last byte is accepted or received; FSM returns to IDLE in that cycle. The next grant is evaluated the following cycle.
- The requester must drop c_req in the ack cycle; c_req still high in the next cycle starts a new request.
- len > DB-1: clamp to DB-1 (transmitted len byte is clamped too).
- Latency, u_wa/u_ra always 1, ADDR_W=DATA_W=32:
  - write, len=3: grant cycle + 12 TX bytes, ack at cycle 13.
  - read, len=1: grant + 7 TX + 2 RX, ack at cycle 10.

Optional Feature:
- Macro: MCTRL_RX_TIMEOUT_EN.
- Defined: in RDATA, a counter resets on each received byte and on entry. Reaching TIMEOUT_CYC gives c_ack with c_err=1 and c_dout=0, then IDLE.
- Undefined: RDATA waits indefinitely; c_err tied 0; the counter is not built.

Decomposition:
- Shared package mctrl_pkg:
  - command constants CMD_RD=8'hC0, CMD_WR=8'h80
  - FSM state encoding
  - byte-count/width helper functions (AB, DB)
- Sub-module mctrl_rr_arb (NCH-wide round-robin arbiter: req, advance -> one-hot grant, pointer register).

Test Plan:
- Write ch0, addr 0x12345678, data 0xDEADBEEF, len 3, u_wa=1 -> TX 80 78 56 34 12 00 03 6F 3E 2D 5E 0F; c_ack[0] at cycle 13, c_err=0.
- Read ch1, addr 0x80000004, len 1; RX bytes 34 12 -> TX C0 04 00 00 00 08 01; c_dout=0x00001234 with c_ack[1].
- c_req=2'b11 simultaneously after reset, both reads -> ch0 served first, then ch1; next simultaneous pair serves ch0 again (pointer wraps).
- u_wa toggled 1/0 every cycle during a write -> same byte sequence, no duplicates or drops, ack delayed accordingly.
- rst asserted during ADDR of a write -> all outputs 0 next cycle; no c_ack; a fresh request afterwards begins with CMD.
- With MCTRL_RX_TIMEOUT_EN, TIMEOUT_CYC=16, read with no RX bytes -> c_ack with c_err=1, c_dout=0, 16 cycles after entering RDATA.
